// File: rtl/fft_frame_scheduler_if.sv
// Streaming bundle for fft_frame_scheduler: two requesters, the FFT chain input
// and output ports, the tagged output stream and the status flags.
interface fft_frame_scheduler_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid, req0_ready;
   logic [WIDTH-1:0] req0_re, req0_im;
   logic             req1_valid, req1_ready;
   logic [WIDTH-1:0] req1_re, req1_im;
   logic             fft_di_en;
   logic [WIDTH-1:0] fft_di_re, fft_di_im;
   logic             fft_do_en;
   logic [WIDTH-1:0] fft_do_re, fft_do_im;
   logic             out_en, out_ch, out_first, out_last;
   logic [WIDTH-1:0] out_re, out_im;
   logic             underrun, orphan, status_clear, busy;

   modport slave (
      input  req0_valid, req0_re, req0_im, req1_valid, req1_re, req1_im,
             fft_do_en, fft_do_re, fft_do_im, status_clear,
      output req0_ready, req1_ready, fft_di_en, fft_di_re, fft_di_im,
             out_en, out_re, out_im, out_ch, out_first, out_last,
             underrun, orphan, busy
   );

   modport master (
      output req0_valid, req0_re, req0_im, req1_valid, req1_re, req1_im,
             fft_do_en, fft_do_re, fft_do_im, status_clear,
      input  req0_ready, req1_ready, fft_di_en, fft_di_re, fft_di_im,
             out_en, out_re, out_im, out_ch, out_first, out_last,
             underrun, orphan, busy
   );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Round-robin frame scheduler sharing one SDF FFT chain between two requesters;
// launched frames are tagged so the output stream can be re-labelled per channel.
module fft_frame_scheduler #(
   parameter int N         = 64,
   parameter int WIDTH     = 16,
   parameter int TAG_DEPTH = 4
) (
   input logic clock,
   input logic reset,
   fft_frame_scheduler_if.slave bus
);
   localparam int CW = $clog2(N);
   localparam int TW = $clog2(TAG_DEPTH);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [TW:0]   FULL = (TW + 1)'(TAG_DEPTH);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t               state, state_nxt;
   logic                 rr, rr_nxt, has_last, has_last_nxt;
   logic [CW-1:0]        in_count, in_count_nxt, out_count;
   logic                 push, pop, room, any_v, arb_ch, at_end;
   logic [TAG_DEPTH-1:0] tag_mem;
   logic [TW-1:0]        wr_ptr, rd_ptr;
   logic [TW:0]          tag_cnt;
   logic                 sel_valid, out_start, frame_ch, frame_ch_nxt;
   logic [WIDTH-1:0]     sel_re, sel_im;

   // rr doubles as the granted channel of the frame currently streaming
   assign sel_valid = rr ? bus.req1_valid : bus.req0_valid;
   assign sel_re    = rr ? bus.req1_re    : bus.req0_re;
   assign sel_im    = rr ? bus.req1_im    : bus.req0_im;

   assign out_start = bus.fft_do_en && (out_count == '0);
   assign pop       = out_start && (tag_cnt != '0);
   assign room      = (tag_cnt != FULL) || pop;
   assign any_v     = bus.req0_valid || bus.req1_valid;
   // until the first grant there is no last winner, so channel 0 takes the tie
   assign arb_ch    = (bus.req0_valid && bus.req1_valid) ? (has_last & ~rr) : bus.req1_valid;
   assign at_end    = (in_count == LAST);

   assign bus.req0_ready = (state == STREAM) && !rr;
   assign bus.req1_ready = (state == STREAM) &&  rr;
   assign bus.busy       = (state != IDLE) || (tag_cnt != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rr       <= 1'b0;
         has_last <= 1'b0;
         in_count <= '0;
      end else begin
         state    <= state_nxt;
         rr       <= rr_nxt;
         has_last <= has_last_nxt;
         in_count <= in_count_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_nxt       = rr;
      has_last_nxt = has_last;
      in_count_nxt = in_count;
      push         = 1'b0;
      case (state)
         IDLE: begin
            if (room && any_v) begin
               push         = 1'b1;
               state_nxt    = STREAM;
               rr_nxt       = arb_ch;
               has_last_nxt = 1'b1;
               in_count_nxt = '0;
            end
         end
         STREAM: begin
            if (!at_end) begin
               in_count_nxt = in_count + 1'b1;
            end else if (room && any_v) begin
               push         = 1'b1;
               rr_nxt       = arb_ch;
               has_last_nxt = 1'b1;
               in_count_nxt = '0;
            end else begin
               state_nxt    = IDLE;
               in_count_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // pop only sees entries committed in earlier cycles: no same-cycle bypass
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_mem <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (push) begin
            tag_mem[wr_ptr] <= arb_ch;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.fft_di_en <= 1'b0;
         bus.fft_di_re <= '0;
         bus.fft_di_im <= '0;
         bus.underrun  <= 1'b0;
      end else begin
         bus.fft_di_en <= (state == STREAM);
         bus.fft_di_re <= (state == STREAM && sel_valid) ? sel_re : '0;
         bus.fft_di_im <= (state == STREAM && sel_valid) ? sel_im : '0;
         if (state == STREAM && !sel_valid) bus.underrun <= 1'b1;
         else if (bus.status_clear)         bus.underrun <= 1'b0;
      end
   end

   assign frame_ch_nxt = out_start ? (pop ? tag_mem[rd_ptr] : 1'b0) : frame_ch;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_count     <= '0;
         frame_ch      <= 1'b0;
         bus.out_en    <= 1'b0;
         bus.out_re    <= '0;
         bus.out_im    <= '0;
         bus.out_ch    <= 1'b0;
         bus.out_first <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.orphan    <= 1'b0;
      end else begin
         if (bus.fft_do_en) out_count <= out_count + 1'b1;
         frame_ch      <= frame_ch_nxt;
         bus.out_en    <= bus.fft_do_en;
         bus.out_re    <= bus.fft_do_en ? bus.fft_do_re : '0;
         bus.out_im    <= bus.fft_do_en ? bus.fft_do_im : '0;
         bus.out_ch    <= bus.fft_do_en && frame_ch_nxt;
         bus.out_first <= out_start;
         bus.out_last  <= bus.fft_do_en && (out_count == LAST);
         if (out_start && tag_cnt == '0) bus.orphan <= 1'b1;
         else if (bus.status_clear)      bus.orphan <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench for fft_frame_scheduler: a frame-level reference model with a
// tag queue predicts every output; the FFT is a 100-cycle delay line or driven by hand.
module tb_fft_frame_scheduler;
   localparam int N = 64, W = 16, D = 4, DLY = 100;

   logic clock = 1'b0;
   logic reset = 1'b0;
   fft_frame_scheduler_if #(.WIDTH(W)) bus();
   fft_frame_scheduler #(.N(N), .WIDTH(W), .TAG_DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   typedef struct packed {logic en; logic [W-1:0] re; logic [W-1:0] im;} smp_t;
   smp_t hist [DLY];

   int total = 0, bad = 0;
   int cyc = 0, pc = 0, vmode = 4, dmode = 1;
   bit force_clr = 0;

   // reference model: frame position counters and an in-flight tag queue
   bit m_stream, m_ch, m_has_last, m_fch;
   int m_pos, m_opos;
   bit tagq[$];
   bit e_di_en, e_out_en, e_ch, e_first, e_last, e_uf, e_orph;
   logic [W-1:0] e_di_re, e_di_im, e_out_re, e_out_im;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_stream = 0; m_ch = 0; m_has_last = 0; m_fch = 0; m_pos = 0; m_opos = 0;
      tagq.delete();
      e_di_en = 0; e_out_en = 0; e_ch = 0; e_first = 0; e_last = 0; e_uf = 0; e_orph = 0;
      e_di_re = '0; e_di_im = '0; e_out_re = '0; e_out_im = '0;
      for (int i = 0; i < DLY; i++) hist[i] = '0;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_r0"}, bus.req0_ready, 0);   chk({p, "_r1"}, bus.req1_ready, 0);
      chk({p, "_di_en"}, bus.fft_di_en, 0); chk({p, "_di_re"}, bus.fft_di_re, 0);
      chk({p, "_di_im"}, bus.fft_di_im, 0); chk({p, "_out_en"}, bus.out_en, 0);
      chk({p, "_out_re"}, bus.out_re, 0);   chk({p, "_out_im"}, bus.out_im, 0);
      chk({p, "_out_ch"}, bus.out_ch, 0);   chk({p, "_first"}, bus.out_first, 0);
      chk({p, "_last"}, bus.out_last, 0);   chk({p, "_underrun"}, bus.underrun, 0);
      chk({p, "_orphan"}, bus.orphan, 0);   chk({p, "_busy"}, bus.busy, 0);
   endtask

   task automatic cycle();
      smp_t lb, cur;
      logic v0, v1, den, clr, vg, start, pop, room, g;
      logic [W-1:0] r0, i0, r1, i1, dre, dim;
      int sz;
      @(negedge clock);
      chk("di_en", bus.fft_di_en, e_di_en);  chk("di_re", bus.fft_di_re, e_di_re);
      chk("di_im", bus.fft_di_im, e_di_im);  chk("out_en", bus.out_en, e_out_en);
      chk("out_re", bus.out_re, e_out_re);   chk("out_im", bus.out_im, e_out_im);
      chk("out_ch", bus.out_ch, e_ch);       chk("out_first", bus.out_first, e_first);
      chk("out_last", bus.out_last, e_last); chk("underrun", bus.underrun, e_uf);
      chk("orphan", bus.orphan, e_orph);     chk("busy", bus.busy, m_stream || tagq.size() != 0);
      cur.en = bus.fft_di_en; cur.re = bus.fft_di_re; cur.im = bus.fft_di_im;
      lb = hist[cyc % DLY];
      hist[cyc % DLY] = cur;
      cyc++;
      case (vmode)
         0: begin v0 = 1; v1 = 0; end
         1: begin v0 = 1; v1 = 1; end
         2: begin v0 = 0; v1 = !(pc >= 30 && pc < 33); end
         3: begin v0 = $urandom_range(0, 4) != 0; v1 = $urandom_range(0, 4) != 0; end
         default: begin v0 = 0; v1 = 0; end
      endcase
      clr = force_clr || (vmode == 3 && $urandom_range(0, 99) == 0);
      r0 = W'($urandom); i0 = W'($urandom); r1 = W'($urandom); i1 = W'($urandom);
      case (dmode)
         0: begin den = lb.en; dre = lb.re; dim = lb.im; end
         2: begin den = $urandom_range(0, 3) != 0; dre = W'($urandom); dim = W'($urandom); end
         3: begin den = 1; dre = W'($urandom); dim = W'($urandom); end
         default: begin den = 0; dre = '0; dim = '0; end
      endcase
      bus.req0_valid = v0; bus.req0_re = r0; bus.req0_im = i0;
      bus.req1_valid = v1; bus.req1_re = r1; bus.req1_im = i1;
      bus.fft_do_en = den; bus.fft_do_re = dre; bus.fft_do_im = dim;
      bus.status_clear = clr;
      pc++;
      #1;
      chk("req0_ready", bus.req0_ready, m_stream && !m_ch);
      chk("req1_ready", bus.req1_ready, m_stream && m_ch);
      // output side: a frame starts every N enabled samples and consumes one tag
      sz = tagq.size();
      start = den && (m_opos == 0);
      pop = start && sz > 0;
      if (start) m_fch = pop ? tagq[0] : 1'b0;
      e_out_en = den; e_out_re = den ? dre : '0; e_out_im = den ? dim : '0;
      e_ch = den && m_fch; e_first = start; e_last = den && (m_opos == N - 1);
      if (start && sz == 0) e_orph = 1; else if (clr) e_orph = 0;
      if (den) m_opos = (m_opos + 1) % N;
      // input side: frames are exactly N cycles, arbitration at frame boundaries
      vg = m_ch ? v1 : v0;
      e_di_en = m_stream;
      e_di_re = (m_stream && vg) ? (m_ch ? r1 : r0) : '0;
      e_di_im = (m_stream && vg) ? (m_ch ? i1 : i0) : '0;
      if (m_stream && !vg) e_uf = 1; else if (clr) e_uf = 0;
      if (pop) void'(tagq.pop_front());
      if (!m_stream || m_pos == N - 1) begin
         room = (sz < D) || pop;
         if (room && (v0 || v1)) begin
            g = (v0 && v1) ? (m_has_last ? !m_ch : 1'b0) : v1;
            tagq.push_back(g);
            m_ch = g; m_has_last = 1; m_stream = 1; m_pos = 0;
         end else begin
            m_stream = 0; m_pos = 0;
         end
      end else begin
         m_pos++;
      end
   endtask

   task automatic run(input int n, input int vm, input int dm);
      vmode = vm; dmode = dm; pc = 0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      bit hit;
      bus.req0_valid = 0; bus.req0_re = '0; bus.req0_im = '0;
      bus.req1_valid = 0; bus.req1_re = '0; bus.req1_im = '0;
      bus.fft_do_en = 0; bus.fft_do_re = '0; bus.fft_do_im = '0;
      bus.status_clear = 0;
      model_reset();
      #22;
      chk_zero("reset");
      @(posedge clock); #2 reset = 1;

      run(200, 0, 0);                 // ch0 alone: back-to-back ch0 frames
      run(300, 1, 0);                 // both: alternating frames, no bubbles
      chk("no_underrun_yet", bus.underrun, 0);
      run(200, 2, 0);                 // ch1 with a 3-cycle valid drop
      chk("underrun_set", bus.underrun, 1);
      force_clr = 1; run(1, 1, 0); force_clr = 0;
      run(1, 1, 0);
      chk("underrun_cleared", bus.underrun, 0);
      run(1500, 3, 0);                // random valids and clears
      run(400, 1, 1);                 // output stalled: tag FIFO fills
      chk("full_ready0", bus.req0_ready, 0);
      chk("full_ready1", bus.req1_ready, 0);
      chk("full_busy", bus.busy, 1);
      run(64, 1, 3);                  // one output frame frees one tag slot
      run(800, 4, 2);                 // drain with gappy output, then orphans
      chk("orphan_set", bus.orphan, 1);
      run(200, 1, 0);

      hit = 0;
      vmode = 1; dmode = 0;
      for (int k = 0; k < 300; k++) begin
         cycle();
         if (m_stream && m_pos == 30) begin hit = 1; break; end
      end
      chk("rst_point_found", hit, 1);
      @(posedge clock); #2 reset = 0;
      #1;
      model_reset();
      chk_zero("midrst");
      repeat (3) @(posedge clock);
      #2 reset = 1;
      run(2, 1, 0);
      chk("rst_first_grant_ch0", bus.req0_ready, 1);
      chk("rst_first_grant_not_ch1", bus.req1_ready, 0);
      run(200, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Shares one SDF FFT pipeline (radix-2^2 stage chain, no backpressure) between two streaming requesters.
- Grants whole N-sample frames round-robin and drives the pipeline's contiguous input enable/data.
- Tags every launched frame with its channel and re-labels the pipeline's output frames with channel, first and last markers.
- Sits between the sensor front-end FIFOs and the FFT chain input/output.

Parameters:
- N, 64, FFT points per frame; power of 2, >=4.
- WIDTH, 16, sample bit length per real/imag component.
- TAG_DEPTH, 4, in-flight frame tag FIFO depth; power of 2, >=2.

Ports:
- clock, input, 1, master clock.
- reset, input, 1, asynchronous active-low reset.
- req0_valid, input, 1, channel 0 sample valid.
- req0_ready, output, 1, channel 0 sample accepted this cycle when valid.
- req0_re, input, WIDTH, channel 0 sample (real).
- req0_im, input, WIDTH, channel 0 sample (imag).
- req1_valid, input, 1, channel 1 sample valid.
- req1_ready, output, 1, channel 1 sample accepted this cycle when valid.
- req1_re, input, WIDTH, channel 1 sample (real).
- req1_im, input, WIDTH, channel 1 sample (imag).
- fft_di_en, output, 1, FFT input enable.
- fft_di_re, output, WIDTH, FFT input data (real).
- fft_di_im, output, WIDTH, FFT input data (imag).
- fft_do_en, input, 1, FFT output enable.
- fft_do_re, input, WIDTH, FFT output data (real).
- fft_do_im, input, WIDTH, FFT output data (imag).
- out_en, output, 1, tagged output valid.
- out_re, output, WIDTH, tagged output data (real).
- out_im, output, WIDTH, tagged output data (imag).
- out_ch, output, 1, channel of current output frame.
- out_first, output, 1, first sample of output frame.
- out_last, output, 1, sample N-1 of output frame.
- underrun, output, 1, sticky: zero-filled an input sample.
- orphan, output, 1, sticky: output frame started with tag FIFO empty.
- status_clear, input, 1, synchronous clear of underrun and orphan.
- busy, output, 1, state != IDLE or tag FIFO non-empty.

Behaviour:
- Reset (reset=0, async): every output 0; state IDLE; rr pointer=0 (channel 0 wins the first tie); tag FIFO empty; all counters 0. Reset mid-frame abandons the frame with no flush; the FFT chain shares this reset.
- States: IDLE, STREAM.
- IDLE -> STREAM when the tag FIFO is not full and any reqX_valid=1.
  - Grant: the valid channel. If both are valid, the channel != rr pointer's last grant.
  - On grant: push channel to tag FIFO; rr pointer <= granted channel; in_count <= 0.
- STREAM, every cycle:
  - reqG_ready=1 for the granted channel G only; the other channel's ready=0.
  - in_count increments each cycle regardless of valid, so the frame is always exactly N cycles.
- fft_di_* are registered, 1 cycle after the STREAM cycle.
  - fft_di_en=1 for exactly N consecutive cycles per frame.
  - Data = accepted sample, or 0/0 when reqG_valid=0; the zero-fill case sets underrun.
- At in_count=N-1, re-arbitrate with the IDLE rules.
  - If a grant is made, the next cycle is in_count=0 of the new frame: no bubble, fft_di_en stays 1 and the tag is pushed.
  - Otherwise go to IDLE and fft_di_en drops after the last sample.
- Tag FIFO full blocks new grants only; it never truncates a frame.
- Output path, registered, latency 1 from fft_do_*:
  - out_en=fft_do_en, out_re/out_im=fft_do_re/im.
  - out_count increments on fft_do_en and wraps N-1 -> 0; it is not reset by gaps in fft_do_en.
- On fft_do_en with out_count=0:
  - Pop the tag; out_ch holds the popped value for the whole frame; out_first=1.
  - If the FIFO is empty: out_ch=0 and orphan set.
- out_last=1 when fft_do_en and out_count=N-1.
- A simultaneous push and pop in the same cycle is legal, including at full (pop frees a slot, grant is allowed) and at empty (the pop sees the pushed tag only if the push was committed in an earlier cycle; same-cycle bypass is not provided).
- status_clear has priority below set: a set in the same cycle wins.
- out_* are driven 0 when out_en=0.

Test Plan:
- Only req0 valid continuously, N=64 -> fft_di_en high for 64 cycles, req0_ready high 64 cycles, then re-grant to ch0 back-to-back with no gap; tag FIFO holds 0,0.
- Both valid continuously -> frames alternate ch0,ch1,ch0,ch1; each frame is 64 contiguous fft_di_en cycles with no bubble between frames.
- req1 drops valid for 3 cycles mid-frame -> those 3 fft_di samples are 0; frame length is still 64; underrun=1 until status_clear.
- Model the FFT as a fixed 100-cycle delay, then launch 2 frames (ch1, ch0) -> out_ch=1 for the first 64 out_en cycles with out_first at sample 0 and out_last at 63, then out_ch=0; busy falls after the final out_last.
- Stall fft_do_en (never pop) and request continuously -> exactly TAG_DEPTH=4 frames launched, then IDLE with ready=0; one frame out -> one more grant.
- Assert reset low mid-STREAM at in_count=30 -> all outputs 0 immediately; after release, the first grant goes to ch0 when both channels are valid.
